mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the datapath memory interface: answers Read/Write
//   requests issued by the control sequencer through MAR/MDR.
//   On a read it returns data on Mdatain for MDR capture; on a write it stores
//   the MDR value.
//   Uses a four-phase Read/Write <-> MemReady handshake with programmable wait
//   states. Sits between MAR/MDR and the rest of the system.
// PARAMETERS
//   ADDR_WIDTH   9    width of Address (MAR low bits)
//   DATA_WIDTH   32   word width
//   DEPTH        512  implemented words; Address >= DEPTH is out of range
//   WAIT_STATES  1    extra cycles between request accept and access (0..15)
// PORTS
//   Clock      in   1           rising-edge clock
//   Clear      in   1           synchronous, active-high reset
//   Read       in   1           read request, held until MemReady seen
//   Write      in   1           write request, held until MemReady seen
//   Address    in   ADDR_WIDTH  word address from MAR
//   MDRdata    in   DATA_WIDTH  write data from MDR
//   Mdatain    out  DATA_WIDTH  read data to MDR; holds last read value
//   MemReady   out  1           access complete (high for whole ACK state)
//   Busy       out  1           state != IDLE
//   Error      out  1           one-cycle pulse: illegal or out-of-range request
// BEHAVIOUR
//   Clear (sampled at a rising edge; overrides all else):
//     state=IDLE; Mdatain=0; MemReady=0; Busy=0; Error=0; cnt=0.
//     Memory array NOT cleared. Clear mid-transaction aborts it; a pending
//     write is not performed.
//   FSM states: IDLE, WAIT, ACK. All outputs are registered.
//   IDLE:
//     - exactly one of Read/Write high at an edge -> accept: latch Address,
//       MDRdata and op; cnt<=WAIT_STATES; go to WAIT.
//     - Read&Write both high -> not accepted; Error=1 for that cycle; stay IDLE.
//   WAIT:
//     - cnt!=0 -> cnt<=cnt-1.
//     - cnt==0 -> perform access and go to ACK:
//         read:  Mdatain<=mem[addr_q]
//         write: mem[addr_q]<=data_q
//   Latency: request sampled at edge k -> access and MemReady=1 after edge
//     k+WAIT_STATES+1.
//   ACK:
//     - MemReady=1.
//     - Read=0 and Write=0 at an edge -> go to IDLE (MemReady=0 next cycle).
//     - Otherwise stay in ACK; a held request is not re-executed (no double
//       access).
//   Address/MDRdata/op changes after accept are ignored until the next accept.
//   Out of range (addr_q >= DEPTH), detected at the access edge:
//     - read: Mdatain<=0; write: no store.
//     - Error=1 for that one cycle, together with the first MemReady cycle.
//   Read-after-write to the same address returns the newly written word.
//   Mdatain changes only on a completed in-range/out-of-range read, or on Clear.
// TESTING
//   1. Clear=1 for 2 cycles -> Mdatain=0, MemReady=0, Busy=0, Error=0.
//   2. WAIT_STATES=1: Write addr 0x010 data 0x00000012, drop after MemReady;
//      Read addr 0x010 -> MemReady rises 2 edges after accept;
//      Mdatain=0x00000012.
//   3. Write 0x014<-0x00000014, then Read 0x014 and Read 0x010 back-to-back ->
//      0x00000014, then 0x00000012; Busy low exactly one cycle between.
//   4. Read and Write both high in IDLE -> Error pulses each cycle, no access,
//      Busy=0; Mdatain unchanged.
//   5. DEPTH=256: Read addr 0x1F0 -> Mdatain=0, Error 1-cycle pulse with
//      MemReady; Write there -> mem unchanged.
//   6. Write 0x020<-0xDEADBEEF, assert Clear in WAIT -> IDLE, MemReady never
//      rises; Read 0x020 -> old value (0 if never written).

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for MAR/MDR: four-phase Read/Write <-> MemReady handshake
// with WAIT_STATES cycles between accept and access; all outputs registered.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] MDRdata,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  MemReady,
  output logic                  Busy,
  output logic                  Error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_q, op_d;          // 1 = write
  logic [DATA_WIDTH-1:0] mdatain_q, mdatain_d;
  logic                  memready_q, memready_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic                  in_range;
  logic [IDX_W-1:0]      mem_idx;
  logic                  mem_we;

  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign mem_idx  = addr_q[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    mdatain_d = mdatain_q;
    error_d   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Read ^ Write) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_STATES[3:0];
          addr_d  = Address;
          data_d  = MDRdata;
          op_d    = Write;
        end else if (Read && Write) begin
          error_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_ACK;
          error_d = ~in_range;
          if (op_q) begin
            mem_we = in_range;
          end else begin
            mdatain_d = in_range ? mem[mem_idx] : '0;
          end
        end
      end
      ST_ACK: begin
        // A request still held here has already been served; only a full drop releases.
        if (!Read && !Write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    memready_d = (state_d == ST_ACK);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= 1'b0;
      mdatain_q  <= '0;
      memready_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_q       <= op_d;
      mdatain_q  <= mdatain_d;
      memready_q <= memready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Array is never cleared; Clear only suppresses an in-flight store.
  always_ff @(posedge Clock) begin
    if (mem_we && !Clear) mem[mem_idx] <= data_q;
  end

  assign Mdatain  = mdatain_q;
  assign MemReady = memready_q;
  assign Busy     = busy_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=256, WAIT_STATES=1).
module tb_mem_responder;

  logic        Clock = 1'b0;
  logic        Clear, Read, Write;
  logic [8:0]  Address;
  logic [31:0] MDRdata, Mdatain;
  logic        MemReady, Busy, Error;

  int total = 0;
  int bad   = 0;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(1)) dut (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
    .Address(Address), .MDRdata(MDRdata), .Mdatain(Mdatain),
    .MemReady(MemReady), .Busy(Busy), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && MemReady !== 1'b1; i++) tick();
    check(tag, {31'd0, MemReady}, 32'd1);
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d, input string tag);
    Write = 1'b1; Address = a; MDRdata = d;
    tick();
    wait_ready(tag);
    Write = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [8:0] a, input logic [31:0] exp, input string tag);
    Read = 1'b1; Address = a;
    tick();
    wait_ready(tag);
    check(tag, Mdatain, exp);
    Read = 1'b0;
    tick();
  endtask

  initial begin
    Clear = 1'b1; Read = 1'b0; Write = 1'b0; Address = '0; MDRdata = '0;
    tick(); tick();
    check("rst_mdatain", Mdatain, 32'd0);
    check("rst_memready", {31'd0, MemReady}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    Clear = 1'b0;
    tick();

    // Write then read with explicit latency; address change after accept is ignored
    do_write(9'h010, 32'h0000_0012, "wr010");
    Read = 1'b1; Address = 9'h010;
    tick();
    check("rd_lat_busy", {31'd0, Busy}, 32'd1);
    check("rd_lat_rdy0", {31'd0, MemReady}, 32'd0);
    Address = 9'h1F0;
    tick();
    check("rd_lat_rdy1", {31'd0, MemReady}, 32'd0);
    tick();
    check("rd_lat_rdy2", {31'd0, MemReady}, 32'd1);
    check("rd010_data", Mdatain, 32'h0000_0012);
    check("rd010_err", {31'd0, Error}, 32'd0);
    tick();
    check("ack_hold_rdy", {31'd0, MemReady}, 32'd1);
    check("ack_hold_busy", {31'd0, Busy}, 32'd1);
    Read = 1'b0;
    tick();
    check("drop_rdy", {31'd0, MemReady}, 32'd0);
    check("drop_busy", {31'd0, Busy}, 32'd0);

    // Back-to-back reads with one idle cycle between
    do_write(9'h014, 32'h0000_0014, "wr014");
    Read = 1'b1; Address = 9'h014;
    tick(); tick(); tick();
    check("b2b_rdy_a", {31'd0, MemReady}, 32'd1);
    check("b2b_data_a", Mdatain, 32'h0000_0014);
    Read = 1'b0;
    tick();
    check("b2b_gap_busy", {31'd0, Busy}, 32'd0);
    Read = 1'b1; Address = 9'h010;
    tick();
    check("b2b_busy_b", {31'd0, Busy}, 32'd1);
    tick(); tick();
    check("b2b_rdy_b", {31'd0, MemReady}, 32'd1);
    check("b2b_data_b", Mdatain, 32'h0000_0012);
    Read = 1'b0;
    tick();

    // Read and Write together: error each cycle, nothing accepted
    Read = 1'b1; Write = 1'b1; Address = 9'h010; MDRdata = 32'hFFFF_FFFF;
    tick();
    check("both_err1", {31'd0, Error}, 32'd1);
    check("both_busy1", {31'd0, Busy}, 32'd0);
    check("both_data", Mdatain, 32'h0000_0012);
    tick();
    check("both_err2", {31'd0, Error}, 32'd1);
    check("both_rdy", {31'd0, MemReady}, 32'd0);
    Read = 1'b0; Write = 1'b0;
    tick();
    check("both_err_clr", {31'd0, Error}, 32'd0);
    do_read(9'h010, 32'h0000_0012, "both_noaccess");

    // Out of range read and write
    do_write(9'h0F0, 32'hA5A5_A5A5, "wr0f0");
    Read = 1'b1; Address = 9'h1F0;
    tick(); tick(); tick();
    check("oor_rd_rdy", {31'd0, MemReady}, 32'd1);
    check("oor_rd_err", {31'd0, Error}, 32'd1);
    check("oor_rd_data", Mdatain, 32'd0);
    tick();
    check("oor_rd_err_pulse", {31'd0, Error}, 32'd0);
    Read = 1'b0;
    tick();
    Write = 1'b1; Address = 9'h1F0; MDRdata = 32'h5A5A_5A5A;
    tick(); tick(); tick();
    check("oor_wr_err", {31'd0, Error}, 32'd1);
    check("oor_wr_data", Mdatain, 32'd0);
    Write = 1'b0;
    tick();
    do_read(9'h0F0, 32'hA5A5_A5A5, "oor_wr_noalias");

    // Clear at the access edge aborts a pending write
    do_write(9'h020, 32'h1111_1111, "wr020");
    Write = 1'b1; Address = 9'h020; MDRdata = 32'hDEAD_BEEF;
    tick();
    check("abort_busy", {31'd0, Busy}, 32'd1);
    tick();
    Clear = 1'b1; Write = 1'b0;
    tick();
    check("abort_busy0", {31'd0, Busy}, 32'd0);
    check("abort_rdy", {31'd0, MemReady}, 32'd0);
    check("abort_mdatain", Mdatain, 32'd0);
    Clear = 1'b0;
    tick(); tick();
    check("abort_rdy_later", {31'd0, MemReady}, 32'd0);
    do_read(9'h020, 32'h1111_1111, "abort_old");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
